// File: rtl/bus_merge_pkg.sv
// Shared types for the bus_merge stream combiner and the bus interface it consumes.
package bus_merge_pkg;
    localparam int DATA_W = 16;
    typedef logic [DATA_W-1:0] dat_t;
endpackage

// File: rtl/bus_if.sv
// Producer-to-consumer word bus with no back-pressure; d is qualified by vld.
interface bus;
    import bus_merge_pkg::*;
    dat_t d;
    logic vld;
    modport m (output d, output vld);
    modport s (input d, input vld);
endinterface

// File: rtl/bus_merge_fifo.sv
// Single-channel synchronous FIFO; a push into a full FIFO is dropped and flagged.
module bus_merge_fifo
    import bus_merge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  dat_t din,
    input  logic pop,
    output dat_t dout,
    output logic empty,
    output logic full,
    output logic ovf_evt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    dat_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ovf_evt = push && full;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/bus_merge.sv
// Merges NCH bus streams into one tagged valid/ready stream via per-channel FIFOs
// and a round-robin arbiter feeding a registered output stage.
module bus_merge
    import bus_merge_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int DEPTH = 4,
    localparam int CH_W  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    bus.s                     bus_in [NCH],
    output logic [DATA_W-1:0] out_d,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [NCH-1:0]    ovf,
    input  logic [NCH-1:0]    ovf_clr
);
    dat_t            head [NCH];
    logic [NCH-1:0]  empty;
    logic [NCH-1:0]  full;
    logic [NCH-1:0]  ovf_evt;
    logic [NCH-1:0]  pop;
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] gnt;
    logic [CH_W-1:0] cand;
    logic            found;
    logic            load;
    int              idx;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        bus_merge_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push    (bus_in[i].vld),
            .din     (bus_in[i].d),
            .pop     (pop[i]),
            .dout    (head[i]),
            .empty   (empty[i]),
            .full    (full[i]),
            .ovf_evt (ovf_evt[i])
        );
    end

    // Full is already folded into ovf_evt inside each FIFO.
    logic unused_full;
    assign unused_full = ^full;

    assign load = !out_vld || out_rdy;

    // Search from ptr+1 upward with wrap; first non-empty channel wins.
    always_comb begin
        found = 1'b0;
        gnt   = ptr;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NCH)
                idx = idx - NCH;
            cand = CH_W'(idx);
            if (!found && !empty[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NCH; i++)
            pop[i] = load && found && (gnt == CH_W'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_d   <= '0;
            out_ch  <= '0;
            out_vld <= 1'b0;
            ptr     <= CH_W'(NCH - 1);
            ovf     <= '0;
        end else begin
            if (load) begin
                if (found) begin
                    out_d   <= head[gnt];
                    out_ch  <= gnt;
                    out_vld <= 1'b1;
                    ptr     <= gnt;
                end else begin
                    out_vld <= 1'b0;
                end
            end
            // A new overflow on the same edge as a clear keeps the flag set.
            ovf <= ovf_evt | (ovf & ~ovf_clr);
        end
    end
endmodule

// File: tb/tb_bus_merge.sv
// Bench for bus_merge: queue-based behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bus_merge;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;
    localparam int CH_W  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [15:0]     drv_d [NCH];
    logic [NCH-1:0]  drv_vld;
    logic            out_rdy;
    logic [NCH-1:0]  ovf_clr;
    logic [15:0]     out_d;
    logic [CH_W-1:0] out_ch;
    logic            out_vld;
    logic [NCH-1:0]  ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus bus_if [NCH] ();

    for (genvar g = 0; g < NCH; g++) begin : g_drv
        assign bus_if[g].d   = drv_d[g];
        assign bus_if[g].vld = drv_vld[g];
    end

    bus_merge #(.NCH(NCH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus_in  (bus_if),
        .out_d   (out_d),
        .out_ch  (out_ch),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-channel queues, an output slot and a last-grant index.
    logic [15:0]    mq [NCH][$];
    logic [15:0]    m_d;
    logic [CH_W-1:0] m_ch;
    logic           m_vld;
    logic [NCH-1:0] m_ovf;
    int             m_last;

    initial begin : model
        int  g;
        int  c;
        bit  wasfull [NCH];
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NCH; i++) mq[i].delete();
                m_d = '0; m_ch = '0; m_vld = 1'b0; m_ovf = '0; m_last = NCH - 1;
            end else begin
                for (int i = 0; i < NCH; i++) wasfull[i] = (mq[i].size() == DEPTH);
                if (!m_vld || out_rdy) begin
                    g = -1;
                    for (int k = 1; k <= NCH; k++) begin
                        c = (m_last + k) % NCH;
                        if (g < 0 && mq[c].size() > 0) g = c;
                    end
                    if (g >= 0) begin
                        m_d = mq[g].pop_front();
                        m_ch = CH_W'(g);
                        m_vld = 1'b1;
                        m_last = g;
                    end else begin
                        m_vld = 1'b0;
                    end
                end
                for (int i = 0; i < NCH; i++) begin
                    if (ovf_clr[i]) m_ovf[i] = 1'b0;
                    if (drv_vld[i]) begin
                        if (wasfull[i]) m_ovf[i] = 1'b1;
                        else mq[i].push_back(drv_d[i]);
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(posedge clk);
            #3;
            chk("model_vld", {31'd0, out_vld}, {31'd0, m_vld});
            chk("model_d", {16'd0, out_d}, {16'd0, m_d});
            chk("model_ch", {30'd0, out_ch}, {30'd0, m_ch});
            chk("model_ovf", {28'd0, ovf}, {28'd0, m_ovf});
        end
    end

    // All stimulus changes at posedge+3, well clear of the sampling edge.
    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        drv_vld = '0;
        ovf_clr = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int n;
        for (int i = 0; i < NCH; i++) drv_d[i] = '0;
        drv_vld = '0;
        out_rdy = 1'b1;
        ovf_clr = '0;
        step();
        chk("rst_vld", {31'd0, out_vld}, 32'd0);
        chk("rst_d", {16'd0, out_d}, 32'd0);
        chk("rst_ovf", {28'd0, ovf}, 32'd0);
        step();
        rst_n = 1'b1;

        // Single word on ch2: visible two edges after the vld cycle.
        drv_d[2] = 16'h1234; drv_vld = 4'b0100;
        step();
        drv_vld = '0;
        chk("t1_early", {31'd0, out_vld}, 32'd0);
        step();
        chk("t1_vld", {31'd0, out_vld}, 32'd1);
        chk("t1_d", {16'd0, out_d}, 32'h1234);
        chk("t1_ch", {30'd0, out_ch}, 32'd2);
        step();
        chk("t1_done", {31'd0, out_vld}, 32'd0);
        chk("t1_ovf", {28'd0, ovf}, 32'd0);

        // Round-robin: two bursts on all channels, both in order 0..3.
        do_reset();
        for (int i = 0; i < NCH; i++) drv_d[i] = 16'(16'hA0 + i);
        drv_vld = '1;
        step();
        drv_vld = '0;
        for (int k = 0; k < NCH; k++) begin
            step();
            chk("t2a_d", {16'd0, out_d}, 32'hA0 + k);
            chk("t2a_ch", {30'd0, out_ch}, k);
        end
        step();
        chk("t2a_idle", {31'd0, out_vld}, 32'd0);
        for (int i = 0; i < NCH; i++) drv_d[i] = 16'(16'hB0 + i);
        drv_vld = '1;
        step();
        drv_vld = '0;
        for (int k = 0; k < NCH; k++) begin
            step();
            chk("t2b_d", {16'd0, out_d}, 32'hB0 + k);
            chk("t2b_ch", {30'd0, out_ch}, k);
        end

        // Back-pressure: 1 in output, 2..5 queued, 6..8 dropped.
        do_reset();
        out_rdy = 1'b0;
        for (int v = 1; v <= 8; v++) begin
            drv_d[1] = 16'(v); drv_vld = 4'b0010;
            step();
        end
        drv_vld = '0;
        chk("t3_hold_vld", {31'd0, out_vld}, 32'd1);
        chk("t3_hold_d", {16'd0, out_d}, 32'd1);
        chk("t3_ovf", {28'd0, ovf}, 32'h2);
        step();
        chk("t3_stable_d", {16'd0, out_d}, 32'd1);
        out_rdy = 1'b1;
        for (int v = 2; v <= 5; v++) begin
            step();
            chk("t3_drain_d", {16'd0, out_d}, v);
            chk("t3_drain_ch", {30'd0, out_ch}, 32'd1);
        end
        step();
        chk("t3_empty", {31'd0, out_vld}, 32'd0);

        // Clear vs set on the same edge, then clear alone.
        do_reset();
        out_rdy = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            drv_d[0] = 16'(v); drv_vld = 4'b0001;
            step();
        end
        chk("t4_ovf_set", {28'd0, ovf}, 32'h1);
        drv_d[0] = 16'd7; ovf_clr = 4'b0001;
        step();
        drv_vld = '0;
        chk("t4_set_wins", {28'd0, ovf}, 32'h1);
        step();
        ovf_clr = '0;
        chk("t4_clr", {28'd0, ovf}, 32'h0);
        out_rdy = 1'b1;
        repeat (6) step();

        // Asynchronous reset while words are queued.
        do_reset();
        out_rdy = 1'b0;
        for (int v = 0; v < 6; v++) begin
            drv_d[0] = 16'(v + 1); drv_d[1] = 16'(16'h11 + v);
            drv_vld = (v < 4) ? 4'b0011 : 4'b0010;
            step();
        end
        drv_vld = '0;
        chk("t5_pre_d", {16'd0, out_d}, 32'd1);
        chk("t5_pre_ovf", {28'd0, ovf}, 32'h2);
        rst_n = 1'b0;
        #1;
        chk("t5_async_vld", {31'd0, out_vld}, 32'd0);
        chk("t5_async_ovf", {28'd0, ovf}, 32'd0);
        #1;
        rst_n = 1'b1;
        out_rdy = 1'b1;
        step();
        chk("t5_no_stale", {31'd0, out_vld}, 32'd0);
        drv_d[3] = 16'h0333; drv_vld = 4'b1000;
        step();
        drv_vld = '0;
        chk("t5_lat", {31'd0, out_vld}, 32'd0);
        step();
        chk("t5_vld", {31'd0, out_vld}, 32'd1);
        chk("t5_d", {16'd0, out_d}, 32'h0333);
        chk("t5_ch", {30'd0, out_ch}, 32'd3);

        // Full throughput: 0..99 on ch0, one output per cycle.
        do_reset();
        out_rdy = 1'b1;
        n = 0;
        fork
            begin
                for (int v = 0; v < 100; v++) begin
                    drv_d[0] = 16'(v); drv_vld = 4'b0001;
                    step();
                end
                drv_vld = '0;
            end
            begin
                repeat (106) begin
                    step();
                    if (n > 0 && n < 100) chk("t6_gap", {31'd0, out_vld}, 32'd1);
                    if (out_vld) begin
                        chk("t6_d", {16'd0, out_d}, n);
                        n++;
                    end
                end
            end
        join
        chk("t6_count", n, 32'd100);
        chk("t6_ovf", {28'd0, ovf}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bus_merge.md
Name: bus_merge

Overview:
Downstream consumer of a `bus` interface array (slave modport): merges NCH independent 16-bit `d`/`vld` streams into one output stream.
- The `bus` protocol has no back-pressure, so each channel lands in a small per-channel FIFO.
- A round-robin arbiter drains the FIFOs into a registered output with a valid/ready handshake. Each output word is tagged with its source channel.
- Sits between traffic generators/producers on `bus` arrays and a single-stream sink such as a capture buffer or serializer.

Parameters:
- NCH, 4, number of input channels; range 2..16.
- DEPTH, 4, per-channel FIFO depth in words; power of two, minimum 2.
- CH_W, $clog2(NCH), width of the channel tag; derived, not overridden.

Ports:
- clk  input  1  single clock for the block and for every bus_in element.
- rst_n  input  1  asynchronous, active-low reset.
- bus_in  input  bus.s[NCH]  interface array, slave modport; d[15:0] is qualified by vld.
- out_d  output  16  merged data.
- out_ch  output  CH_W  source channel index of out_d.
- out_vld  output  1  out_d/out_ch are valid.
- out_rdy  input  1  sink accepts the word this cycle.
- ovf  output  NCH  per-channel sticky overflow flags.
- ovf_clr  input  NCH  per-channel synchronous clear of ovf.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low (rst_n).
  - During reset: all FIFOs empty, out_vld=0, out_d=0, out_ch=0, ovf=0, round-robin pointer=NCH-1 so channel 0 has first priority.
  - Deassertion is clean; the first push is accepted on the first posedge after release.
- Capture:
  - On each posedge, bus_in[i].d is written to FIFO i if bus_in[i].vld=1 and FIFO i is not full.
  - "Full" is evaluated from the state before the edge. A same-cycle pop does not free space for the push, so push-to-full is always dropped.
- Overflow:
  - A vld=1 sample into a full FIFO is discarded and ovf[i] is set at that edge.
  - ovf[i] holds until ovf_clr[i]=1 is sampled. If clear and a new overflow occur on the same edge, set wins (ovf[i] stays 1).
- Output register: loads when out_vld=0 or out_rdy=1; this is the load condition.
  - On load, if any FIFO is non-empty, the arbiter grants one channel g: out_d takes the head of FIFO g, out_ch=g, out_vld=1, FIFO g pops.
  - On load with all FIFOs empty, out_vld=0; out_d/out_ch hold their last value.
  - While out_vld=1 and out_rdy=0, out_d/out_ch/out_vld are stable and no pop occurs.
- Arbitration: round-robin. Search starts at (ptr+1) mod NCH and wraps past NCH-1 to 0. The first non-empty channel wins. ptr updates to g only on a grant.
- Latency: vld high in cycle 0 → word in FIFO at edge 1 → out_vld=1 after edge 2, if the output is free and no other channel wins.
  - Sustained throughput is one word per cycle with out_rdy=1.
  - Aggregate input above one word per cycle eventually overflows. This is intended and flagged.
- Ordering: words are in order within a channel. There is no ordering guarantee across channels beyond round-robin.
- FIFO pointers: log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH.

Decomposition:
- Package bus_merge_pkg: DATA_W=16 constant and the dat_t typedef (logic [DATA_W-1:0]).
- Sub-module bus_merge_fifo: single-channel synchronous FIFO parameterised by DEPTH.
  - Ports: clk, rst_n, push, din, pop, dout, empty, full, ovf_evt.
  - Instantiated NCH times in a generate loop.
- Arbiter and output register live inline in bus_merge.

Test Plan:
1. Single channel: ch2 drives d=0x1234 with vld=1 for 1 cycle, out_rdy=1 → out_vld=1 exactly 2 cycles later with out_d=0x1234, out_ch=2, for 1 cycle; ovf=0.
2. Round-robin: all 4 channels vld=1 for one cycle with d=0xA0+i, out_rdy=1 → 4 consecutive words 0xA0,0xA1,0xA2,0xA3 with out_ch 0,1,2,3. A second burst after ch3 was last again yields order 0,1,2,3.
3. Back-pressure and overflow: DEPTH=4, out_rdy=0, ch1 pushes d=1..8 on consecutive cycles.
   - out_d holds 1; the FIFO holds 2..5; words 6..8 are dropped; ovf[1]=1.
   - Releasing out_rdy yields 1,2,3,4,5 only.
4. Clear vs set: with FIFO0 full, assert ovf_clr[0] on the same edge as another ch0 push → ovf[0] stays 1. Clear alone on the next cycle → ovf[0]=0.
5. Reset mid-operation: with 3 words queued and out_vld=1, pulse rst_n low asynchronously between edges.
   - out_vld drops immediately; ovf=0.
   - After release, no stale words emerge; a new push on ch3 appears with out_ch=3 after 2 cycles.
6. Full throughput: ch0 pushes a 0..99 counter every cycle, out_rdy=1 → output is 0..99 in order, one per cycle, no ovf.
